// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: groups the instruction-memory handshake, the decoder-side
// valid/ready channel and the redirect request into one bundle.
// master: the fetch stage (drives requests and the queue head).
// slave : the environment (memory, decoder and branch resolution).
interface ifetch_queue_if;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memGnt;
    logic        memRvalid;
    logic [31:0] memRdata;
    logic        instValid;
    logic [31:0] instData;
    logic [31:0] instPc;
    logic        instReady;
    logic        redirect;
    logic [31:0] redirectPc;

    modport master (
        output memReq, memAddr, instValid, instData, instPc,
        input  memGnt, memRvalid, memRdata, instReady, redirect, redirectPc
    );

    modport slave (
        input  memReq, memAddr, instValid, instData, instPc,
        output memGnt, memRvalid, memRdata, instReady, redirect, redirectPc
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction fetch with a single outstanding memory
// request, a DEPTH-entry {pc, word} FIFO towards the decoder and a redirect
// path that flushes the queue and restarts fetch.
// Optional build macro IFQ_BYPASS_EN: a response arriving while the queue is
// empty is presented to the decoder in the same cycle.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    ifetch_queue_if.master bus
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {ST_REQ, ST_WAIT} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     req_pc_q, req_pc_d;
    logic            discard_q, discard_d;
    logic            req_hold_q, req_hold_d;
    logic [AW:0]     count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;

    logic [31:0]     pc_mem   [DEPTH];
    logic [31:0]     data_mem [DEPTH];

    logic            queue_valid;
    logic            bypass_valid;
    logic            mem_req;
    logic            grant;
    logic            rsp_accept;
    logic            push;
    logic            pop;

    // Handshake decode: request gating, response acceptance, push/pop and bypass.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        queue_valid = (count_q != '0);
        // The slot check only matters in REQ, where nothing is outstanding,
        // so count<DEPTH equals count+outstanding<DEPTH here.
        mem_req     = (state_q == ST_REQ) && (count_q < FULL_CNT) && !req_hold_q && !rst;
        grant       = mem_req && bus.memGnt;
        rsp_accept  = (state_q == ST_WAIT) && bus.memRvalid && !discard_q && !bus.redirect;
`ifdef IFQ_BYPASS_EN
        bypass_valid = rsp_accept && !queue_valid;
`else
        bypass_valid = 1'b0;
`endif
        push = rsp_accept && !(bypass_valid && bus.instReady);
        pop  = queue_valid && bus.instReady && !bus.redirect;
    end

    // Next-state logic for the fetch FSM, fetch PC and discard flag.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        req_hold_d = 1'b0;
        case (state_q)
            ST_REQ: begin
                if (grant) begin
                    state_d    = ST_WAIT;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    // A redirect racing the grant cannot cancel it: the
                    // response still comes back and must be dropped.
                    if (bus.redirect) discard_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.memRvalid) begin
                    state_d   = ST_REQ;
                    discard_d = 1'b0;
                end else if (bus.redirect) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = ST_REQ;
        endcase
        if (bus.redirect) fetch_pc_d = {bus.redirectPc[31:2], 2'b00};
    end

    // Next-state logic for the FIFO pointers and occupancy.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            discard_q  <= 1'b0;
            req_hold_q <= 1'b1;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
            req_hold_q <= req_hold_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; occupancy gates every read,
        // so stale contents are never visible and the array can map to RAM.
        if (push) begin
            pc_mem[wr_ptr_q]   <= req_pc_q;
            data_mem[wr_ptr_q] <= bus.memRdata;
        end
    end

    // Output drive: queue head, or the bypassed response, or zeros when idle.
    always_comb begin
        bus.memReq    = mem_req;
        bus.memAddr   = fetch_pc_q;
        bus.instValid = queue_valid || bypass_valid;
        bus.instData  = '0;
        bus.instPc    = '0;
        if (queue_valid) begin
            bus.instData = data_mem[rd_ptr_q];
            bus.instPc   = pc_mem[rd_ptr_q];
        end else if (bypass_valid) begin
            bus.instData = bus.memRdata;
            bus.instPc   = req_pc_q;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed scenarios for ifetch_queue (default build, DEPTH=4).
module tb_ifetch_queue;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [31:0] words [4] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};

    ifetch_queue_if bus ();

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.memGnt     = 1'b0;
        bus.memRvalid  = 1'b0;
        bus.memRdata   = 32'h0;
        bus.instReady  = 1'b0;
        bus.redirect   = 1'b0;
        bus.redirectPc = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Wait for memReq with a cycle budget; an expired budget is a failure.
    task automatic wait_req(input int budget);
        int n;
        n = 0;
        while (bus.memReq !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        total++;
        if (bus.memReq !== 1'b1) begin
            bad++;
            $display("FAIL wait_memReq timeout after %0d cycles got=%b exp=1", n, bus.memReq);
        end
    endtask

    // Grant the current request, return the word one cycle later.
    task automatic do_fetch(input logic [31:0] data);
        bus.memGnt = 1'b1;
        step();
        bus.memGnt    = 1'b0;
        bus.memRvalid = 1'b1;
        bus.memRdata  = data;
        step();
        bus.memRvalid = 1'b0;
        bus.memRdata  = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        total++; if (bus.instValid !== 1'b0) begin bad++; $display("FAIL reset_instValid got=%b exp=0", bus.instValid); end
        total++; if (bus.memReq !== 1'b0) begin bad++; $display("FAIL reset_memReq got=%b exp=0", bus.memReq); end
        total++; if (bus.memAddr !== 32'h0) begin bad++; $display("FAIL reset_memAddr got=%h exp=00000000", bus.memAddr); end
        total++; if (bus.instPc !== 32'h0) begin bad++; $display("FAIL reset_instPc got=%h exp=00000000", bus.instPc); end
        total++; if (bus.instData !== 32'h0) begin bad++; $display("FAIL reset_instData got=%h exp=00000000", bus.instData); end
        rst = 1'b0;
        total++; if (bus.memReq !== 1'b0) begin bad++; $display("FAIL reset_hold_memReq got=%b exp=0", bus.memReq); end
        step();
        total++; if (bus.memReq !== 1'b1) begin bad++; $display("FAIL post_reset_memReq got=%b exp=1", bus.memReq); end
        total++; if (bus.memAddr !== 32'h0) begin bad++; $display("FAIL post_reset_memAddr got=%h exp=00000000", bus.memAddr); end
    endtask

    task automatic test_sequential_fetch();
        do_reset();
        bus.instReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_req(5);
            total++; if (bus.memAddr !== 32'(4*i)) begin bad++; $display("FAIL seq_memAddr[%0d] got=%h exp=%h", i, bus.memAddr, 32'(4*i)); end
            do_fetch(words[i]);
            total++; if (bus.instValid !== 1'b1) begin bad++; $display("FAIL seq_instValid[%0d] got=%b exp=1", i, bus.instValid); end
            total++; if (bus.instPc !== 32'(4*i)) begin bad++; $display("FAIL seq_instPc[%0d] got=%h exp=%h", i, bus.instPc, 32'(4*i)); end
            total++; if (bus.instData !== words[i]) begin bad++; $display("FAIL seq_instData[%0d] got=%h exp=%h", i, bus.instData, words[i]); end
        end
        bus.instReady = 1'b0;
    endtask

    task automatic test_full_queue();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait_req(5);
            total++; if (bus.memAddr !== 32'(4*i)) begin bad++; $display("FAIL full_memAddr[%0d] got=%h exp=%h", i, bus.memAddr, 32'(4*i)); end
            do_fetch(words[i]);
        end
        total++; if (bus.memReq !== 1'b0) begin bad++; $display("FAIL full_memReq got=%b exp=0", bus.memReq); end
        total++; if (bus.instPc !== 32'h0) begin bad++; $display("FAIL full_head_pc got=%h exp=00000000", bus.instPc); end
        step();
        step();
        total++; if (bus.memReq !== 1'b0) begin bad++; $display("FAIL full_stays_memReq got=%b exp=0", bus.memReq); end
        bus.instReady = 1'b1;
        step();
        bus.instReady = 1'b0;
        total++; if (bus.memReq !== 1'b1) begin bad++; $display("FAIL after_pop_memReq got=%b exp=1", bus.memReq); end
        total++; if (bus.memAddr !== 32'h10) begin bad++; $display("FAIL after_pop_memAddr got=%h exp=00000010", bus.memAddr); end
        total++; if (bus.instPc !== 32'h4) begin bad++; $display("FAIL after_pop_head_pc got=%h exp=00000004", bus.instPc); end
    endtask

    task automatic test_push_pop();
        do_reset();
        wait_req(5);
        do_fetch(32'h0000_0077);
        total++; if (bus.instPc !== 32'h0) begin bad++; $display("FAIL pp_first_pc got=%h exp=00000000", bus.instPc); end
        bus.memGnt = 1'b1;
        step();
        bus.memGnt    = 1'b0;
        bus.memRvalid = 1'b1;
        bus.memRdata  = 32'h0000_0088;
        bus.instReady = 1'b1;
        step();
        bus.memRvalid = 1'b0;
        bus.instReady = 1'b0;
        total++; if (bus.instValid !== 1'b1) begin bad++; $display("FAIL pp_instValid got=%b exp=1", bus.instValid); end
        total++; if (bus.instPc !== 32'h4) begin bad++; $display("FAIL pp_instPc got=%h exp=00000004", bus.instPc); end
        total++; if (bus.instData !== 32'h88) begin bad++; $display("FAIL pp_instData got=%h exp=00000088", bus.instData); end
        total++; if (bus.memReq !== 1'b1) begin bad++; $display("FAIL pp_memReq got=%b exp=1", bus.memReq); end
        total++; if (bus.memAddr !== 32'h8) begin bad++; $display("FAIL pp_memAddr got=%h exp=00000008", bus.memAddr); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        bus.instReady = 1'b1;
        wait_req(5);
        bus.memGnt = 1'b1;
        step();
        bus.memGnt     = 1'b0;
        bus.redirect   = 1'b1;
        bus.redirectPc = 32'h0000_0103;
        step();
        bus.redirect = 1'b0;
        total++; if (bus.memReq !== 1'b0) begin bad++; $display("FAIL rw_wait_memReq got=%b exp=0", bus.memReq); end
        total++; if (bus.memAddr !== 32'h100) begin bad++; $display("FAIL rw_memAddr got=%h exp=00000100", bus.memAddr); end
        bus.memRvalid = 1'b1;
        bus.memRdata  = 32'hDEAD_BEEF;
        step();
        bus.memRvalid = 1'b0;
        total++; if (bus.instValid !== 1'b0) begin bad++; $display("FAIL rw_dropped_instValid got=%b exp=0", bus.instValid); end
        total++; if (bus.memReq !== 1'b1) begin bad++; $display("FAIL rw_restart_memReq got=%b exp=1", bus.memReq); end
        total++; if (bus.memAddr !== 32'h100) begin bad++; $display("FAIL rw_restart_memAddr got=%h exp=00000100", bus.memAddr); end
        do_fetch(32'h1111_1111);
        total++; if (bus.instPc !== 32'h100) begin bad++; $display("FAIL rw_instPc got=%h exp=00000100", bus.instPc); end
        total++; if (bus.instData !== 32'h1111_1111) begin bad++; $display("FAIL rw_instData got=%h exp=11111111", bus.instData); end
        bus.instReady = 1'b0;
    endtask

    task automatic test_redirect_grant();
        do_reset();
        bus.instReady = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_req(5);
            do_fetch(words[i]);
        end
        total++; if (bus.memAddr !== 32'h8) begin bad++; $display("FAIL rg_memAddr got=%h exp=00000008", bus.memAddr); end
        bus.memGnt     = 1'b1;
        bus.redirect   = 1'b1;
        bus.redirectPc = 32'h0000_0040;
        step();
        bus.memGnt   = 1'b0;
        bus.redirect = 1'b0;
        total++; if (bus.memReq !== 1'b0) begin bad++; $display("FAIL rg_wait_memReq got=%b exp=0", bus.memReq); end
        total++; if (bus.memAddr !== 32'h40) begin bad++; $display("FAIL rg_memAddr_not44 got=%h exp=00000040", bus.memAddr); end
        total++; if (bus.instValid !== 1'b0) begin bad++; $display("FAIL rg_flush_instValid got=%b exp=0", bus.instValid); end
        bus.memRvalid = 1'b1;
        bus.memRdata  = 32'h0BAD_0BAD;
        step();
        bus.memRvalid = 1'b0;
        total++; if (bus.instValid !== 1'b0) begin bad++; $display("FAIL rg_dropped_instValid got=%b exp=0", bus.instValid); end
        total++; if (bus.memReq !== 1'b1) begin bad++; $display("FAIL rg_restart_memReq got=%b exp=1", bus.memReq); end
        total++; if (bus.memAddr !== 32'h40) begin bad++; $display("FAIL rg_restart_memAddr got=%h exp=00000040", bus.memAddr); end
        do_fetch(32'h2222_2222);
        total++; if (bus.instPc !== 32'h40) begin bad++; $display("FAIL rg_instPc got=%h exp=00000040", bus.instPc); end
        total++; if (bus.instData !== 32'h2222_2222) begin bad++; $display("FAIL rg_instData got=%h exp=22222222", bus.instData); end
        bus.instReady = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        bus.redirect   = 1'b1;
        bus.redirectPc = 32'hFFFF_FFFF;
        step();
        bus.redirect = 1'b0;
        total++; if (bus.memReq !== 1'b1) begin bad++; $display("FAIL wrap_memReq got=%b exp=1", bus.memReq); end
        total++; if (bus.memAddr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top_memAddr got=%h exp=fffffffc", bus.memAddr); end
        bus.memGnt = 1'b1;
        step();
        bus.memGnt = 1'b0;
        total++; if (bus.memAddr !== 32'h0) begin bad++; $display("FAIL wrap_memAddr got=%h exp=00000000", bus.memAddr); end
        bus.memRvalid = 1'b1;
        bus.memRdata  = 32'h0000_0033;
        step();
        bus.memRvalid = 1'b0;
        total++; if (bus.instPc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_instPc got=%h exp=fffffffc", bus.instPc); end
        total++; if (bus.instData !== 32'h33) begin bad++; $display("FAIL wrap_instData got=%h exp=00000033", bus.instData); end
        total++; if (bus.memAddr !== 32'h0) begin bad++; $display("FAIL wrap_next_memAddr got=%h exp=00000000", bus.memAddr); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        wait_req(5);
        do_fetch(32'h0000_00A0);
        do_fetch(32'h0000_00A1);
        bus.memGnt = 1'b1;
        step();
        bus.memGnt = 1'b0;
        total++; if (bus.instValid !== 1'b1) begin bad++; $display("FAIL rm_pre_instValid got=%b exp=1", bus.instValid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.memRvalid = 1'b1;
        bus.memRdata  = 32'h0000_0055;
        total++; if (bus.instValid !== 1'b0) begin bad++; $display("FAIL rm_instValid got=%b exp=0", bus.instValid); end
        total++; if (bus.memAddr !== 32'h0) begin bad++; $display("FAIL rm_memAddr got=%h exp=00000000", bus.memAddr); end
        total++; if (bus.memReq !== 1'b0) begin bad++; $display("FAIL rm_memReq got=%b exp=0", bus.memReq); end
        step();
        bus.memRvalid = 1'b0;
        total++; if (bus.instValid !== 1'b0) begin bad++; $display("FAIL rm_stale_instValid got=%b exp=0", bus.instValid); end
        total++; if (bus.memReq !== 1'b1) begin bad++; $display("FAIL rm_restart_memReq got=%b exp=1", bus.memReq); end
        total++; if (bus.memAddr !== 32'h0) begin bad++; $display("FAIL rm_restart_memAddr got=%h exp=00000000", bus.memAddr); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_sequential_fetch();
        test_full_queue();
        test_push_pop();
        test_redirect_wait();
        test_redirect_grant();
        test_wrap();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
